// File: rtl/lms_pkg.sv
// Shared types and constants for the LMS coefficient-update engine.
// The saturation limit helpers take the weight width so every user derives them the same way.
package lms_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } lms_state_e;

  localparam int TAPS_DEF     = 4;
  localparam int DW_DEF       = 10;
  localparam int WW_DEF       = 10;
  localparam int MU_SHIFT_DEF = 4;

  function automatic int w_max(input int ww);
    return (1 << (ww - 1)) - 1;
  endfunction

  function automatic int w_min(input int ww);
    return -(1 << (ww - 1));
  endfunction

  localparam int W_MAX_DEF = (1 << (WW_DEF - 1)) - 1;
  localparam int W_MIN_DEF = -(1 << (WW_DEF - 1));

endpackage

// File: rtl/lms_sat_mac.sv
// One-tap LMS step: w + ((e * x) >>> MU_SHIFT), saturated to the weight range.
// Purely combinational; the top time-shares a single instance across all taps.
module lms_sat_mac
  import lms_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int WW       = WW_DEF,
  parameter int MU_SHIFT = MU_SHIFT_DEF
) (
  input  logic signed [DW-1:0] err_val,
  input  logic signed [DW-1:0] x_val,
  input  logic signed [WW-1:0] w_in,
  output logic signed [WW-1:0] w_next
);

  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 1;
  localparam logic signed [SW-1:0] SUM_MAX = SW'(w_max(WW));
  localparam logic signed [SW-1:0] SUM_MIN = SW'(w_min(WW));

  logic signed [PW-1:0] e_ext;
  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] product;
  logic signed [PW-1:0] delta;
  logic signed [SW-1:0] w_ext;
  logic signed [SW-1:0] d_ext;
  logic signed [SW-1:0] sum;

  always_comb begin
    e_ext   = {{DW{err_val[DW-1]}}, err_val};
    x_ext   = {{DW{x_val[DW-1]}}, x_val};
    product = e_ext * x_ext;
    // Arithmetic shift floors, so tiny negative steps still move the weight by -1.
    delta   = product >>> MU_SHIFT;
    w_ext   = {{(SW - WW){w_in[WW-1]}}, w_in};
    d_ext   = {delta[PW-1], delta};
    sum     = w_ext + d_ext;
    if (sum > SUM_MAX) begin
      w_next = SUM_MAX[WW-1:0];
    end else if (sum < SUM_MIN) begin
      w_next = SUM_MIN[WW-1:0];
    end else begin
      w_next = sum[WW-1:0];
    end
  end

endmodule

// File: rtl/lms_weight_update.sv
// Serial LMS weight updater: owns the input delay line and rewrites one tap weight per clock.
// state     | meaning
// ST_IDLE   | waiting; accepts an error (priority) or a new sample
// ST_UPDATE | writing w[k], k = 0..TAPS-1, one tap per cycle
// ST_DONE   | one-cycle done pulse, then back to ST_IDLE
module lms_weight_update
  import lms_pkg::*;
#(
  parameter int TAPS     = TAPS_DEF,
  parameter int DW       = DW_DEF,
  parameter int WW       = WW_DEF,
  parameter int MU_SHIFT = MU_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x_valid,
  input  logic [DW-1:0]      x_in,
  output logic               x_ready,
  input  logic               err_valid,
  input  logic [DW-1:0]      err,
  output logic               err_ready,
  output logic               busy,
  output logic               done,
  output logic [TAPS*WW-1:0] w_out
);

  localparam int IW = $clog2(TAPS);
  localparam logic [IW-1:0] K_LAST = IW'(TAPS - 1);

  lms_state_e           state;
  logic [IW-1:0]        k;
  logic signed [DW-1:0] err_reg;
  logic signed [DW-1:0] x_dl [TAPS];
  logic signed [WW-1:0] w    [TAPS];
  logic signed [DW-1:0] x_sel;
  logic signed [WW-1:0] w_sel;
  logic signed [WW-1:0] w_next;

  assign x_sel = x_dl[k];
  assign w_sel = w[k];

  lms_sat_mac #(
    .DW       (DW),
    .WW       (WW),
    .MU_SHIFT (MU_SHIFT)
  ) u_mac (
    .err_val (err_reg),
    .x_val   (x_sel),
    .w_in    (w_sel),
    .w_next  (w_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      err_reg <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_dl[i] <= '0;
        w[i]    <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (err_valid) begin
            err_reg <= err;
            k       <= '0;
            state   <= ST_UPDATE;
          end else if (x_valid) begin
            x_dl[0] <= x_in;
            for (int i = 1; i < TAPS; i++) x_dl[i] <= x_dl[i-1];
          end
        end
        ST_UPDATE: begin
          w[k] <= w_next;
          if (k == K_LAST) begin
            state <= ST_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The error wins a same-cycle tie so the delay line stays frozen during an update.
  assign err_ready = (state == ST_IDLE);
  assign x_ready   = (state == ST_IDLE) && !err_valid;
  assign busy      = (state == ST_UPDATE) || (state == ST_DONE);
  assign done      = (state == ST_DONE);

  always_comb begin
    w_out = '0;
    for (int i = 0; i < TAPS; i++) w_out[i*WW +: WW] = w[i];
  end

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed bench for lms_weight_update with hand-computed weights and handshake timing.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_lms_weight_update;

  localparam int TAPS = 4;
  localparam int DW   = 10;
  localparam int WW   = 10;
  localparam int MU   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               x_valid;
  logic [DW-1:0]      x_in;
  logic               x_ready;
  logic               err_valid;
  logic [DW-1:0]      err;
  logic               err_ready;
  logic               busy;
  logic               done;
  logic [TAPS*WW-1:0] w_out;

  int n_checks = 0;
  int n_errors = 0;

  lms_weight_update #(.TAPS(TAPS), .DW(DW), .WW(WW), .MU_SHIFT(MU)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_valid   (x_valid),
    .x_in      (x_in),
    .x_ready   (x_ready),
    .err_valid (err_valid),
    .err       (err),
    .err_ready (err_ready),
    .busy      (busy),
    .done      (done),
    .w_out     (w_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint w_at(input int idx);
    logic signed [WW-1:0] t;
    t = w_out[idx*WW +: WW];
    return longint'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    x_valid = 1'b0;
    err_valid = 1'b0;
    x_in = '0;
    err = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_x(input int v);
    bit ok;
    ok = 1'b0;
    x_valid = 1'b1;
    x_in = DW'(v);
    for (int n = 0; n < 20 && !ok; n++) begin
      if (x_ready) ok = 1'b1;
      tick();
    end
    x_valid = 1'b0;
    if (!ok) check("x_handshake_timeout", 0, 1);
  endtask

  // Returns edges from acceptance to done, number of done samples, and busy samples.
  task automatic send_err(input int v, output int done_at, output int done_cnt, output int busy_cnt);
    bit ok;
    ok = 1'b0;
    done_at = -1;
    done_cnt = 0;
    busy_cnt = 0;
    err_valid = 1'b1;
    err = DW'(v);
    for (int n = 0; n < 20 && !ok; n++) begin
      if (err_ready) ok = 1'b1;
      tick();
    end
    err_valid = 1'b0;
    if (!ok) begin
      check("err_handshake_timeout", 0, 1);
      return;
    end
    for (int n = 0; n < 20; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (!busy) break;
      tick();
    end
  endtask

  task automatic check_all_w(input string tag, input int exp);
    for (int i = 0; i < TAPS; i++) check($sformatf("%s_w%0d", tag, i), w_at(i), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int da, dc, bc;

    do_reset();
    check("rst_w_out", w_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_ready", err_ready, 1);
    check("rst_x_ready", x_ready, 1);

    // Basic update: x = {16, 32, -16, 0}, err = 64
    push_x(0); push_x(-16); push_x(32); push_x(16);
    send_err(64, da, dc, bc);
    check("basic_w0", w_at(0), 64);
    check("basic_w1", w_at(1), 128);
    check("basic_w2", w_at(2), -64);
    check("basic_w3", w_at(3), 0);
    check("basic_done_edge", da, TAPS);
    check("basic_done_width", dc, 1);
    check("basic_busy_cycles", bc, TAPS + 1);
    check("basic_err_ready_back", err_ready, 1);

    // Positive then negative saturation
    do_reset();
    for (int i = 0; i < TAPS; i++) push_x(511);
    send_err(511, da, dc, bc);
    check_all_w("sat_pos1", 511);
    send_err(511, da, dc, bc);
    check_all_w("sat_pos2", 511);
    send_err(-512, da, dc, bc);
    check_all_w("sat_neg", -512);

    // Truncation toward negative infinity
    do_reset();
    push_x(1);
    send_err(1, da, dc, bc);
    check("trunc_pos_w0", w_at(0), 0);
    send_err(-1, da, dc, bc);
    check("trunc_neg_w0", w_at(0), -1);
    check("trunc_neg_w1", w_at(1), 0);

    // Error and sample offered together: error wins, delay line frozen
    do_reset();
    push_x(2);
    x_valid = 1'b1;
    x_in = DW'(100);
    err_valid = 1'b1;
    err = DW'(16);
    #1;
    check("tie_x_ready", x_ready, 0);
    check("tie_err_ready", err_ready, 1);
    tick();
    err_valid = 1'b0;
    for (int n = 0; n < 20 && busy; n++) tick();
    check("tie_w0", w_at(0), 2);
    check("tie_w1", w_at(1), 0);
    check("tie_x_ready_idle", x_ready, 1);
    tick();
    x_valid = 1'b0;
    send_err(16, da, dc, bc);
    check("tie_after_w0", w_at(0), 102);
    check("tie_after_w1", w_at(1), 2);

    // Async reset while k = 2
    do_reset();
    push_x(16); push_x(16); push_x(16);
    err_valid = 1'b1;
    err = DW'(64);
    tick();
    err_valid = 1'b0;
    tick();
    tick();
    check("mid_w0_before", w_at(0), 64);
    rst = 1'b1;
    #1;
    check("mid_rst_w_out", w_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    tick();
    check("mid_rst_no_done", done, 0);
    rst = 1'b0;
    push_x(16);
    send_err(64, da, dc, bc);
    check("mid_after_w0", w_at(0), 64);
    check("mid_after_w1", w_at(1), 0);
    check("mid_after_done", dc, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
